ahb_sram_subordinate_v2: RTL
============================

Name: ahb_sram_subordinate_v2

Overview:
Parametrised AHB-Lite subordinate with a word-organised SRAM. It replaces the single-width slave with configurable data width, depth and wait states, and adds per-byte lane writes. Alignment, size, range and wrap-sequence errors are signalled with the standard two-cycle ERROR response. It sits behind the address decoder and mux, one instance per subordinate slot.

Parameters:
DATA_WIDTH, 32, bus width in bits; one of 32/64/128.
ADDR_WIDTH, 32, HADDR width.
MEM_DEPTH, 16, number of DATA_WIDTH-bit words.
WAIT_STATES, 0, HREADYout-low cycles inserted per OKAY data phase; range 0..15.
SLOT_BITS, 2, upper HADDR bits used by the decoder; they are ignored here.

Ports:
HCLK  in  1  clock, all logic on rising edge.
HRESET  in  1  synchronous reset, active high.
HSEL  in  1  subordinate select.
HADDR  in  ADDR_WIDTH  byte address.
HTRANS  in  2  IDLE=00 BUSY=01 NONSEQ=10 SEQ=11.
HWRITE  in  1  1 = write.
HSIZE  in  3  transfer size, log2 bytes.
HBURST  in  3  SINGLE/INCR/WRAP4/INCR4/WRAP8/INCR8/WRAP16/INCR16.
HWDATA  in  DATA_WIDTH  write data, data phase.
HREADYin  in  1  bus-wide ready.
HRDATA  out  DATA_WIDTH  read data.
HRESP  out  2  00 OKAY, 01 ERROR.
HREADYout  out  1  subordinate ready.

Behaviour:
- Reset: while HRESET=1 at a clock edge, HREADYout=1, HRESP=00, HRDATA=0, state=IDLE, wait counter=0, wrap tracker cleared. Memory contents are not cleared. Reset mid-transfer abandons the transfer and performs no write.
- Accept: an address phase is accepted when HSEL & HREADYin & HTRANS[1]=1. The control signals are registered on acceptance. IDLE/BUSY, or HSEL=0, gives a zero-wait OKAY.
- Word index = HADDR[ADDR_WIDTH-SLOT_BITS-1 : log2(DATA_WIDTH/8)]. Byte lane offset = low log2(DATA_WIDTH/8) bits.
- Error checks, evaluated at acceptance:
  - size: HSIZE > log2(DATA_WIDTH/8);
  - alignment: HADDR not a multiple of 2^HSIZE;
  - range: index >= MEM_DEPTH;
  - wrap: for a SEQ beat of a WRAPn burst, HADDR differs from the expected address. Expected address = previous address + 2^HSIZE, wrapped within a block of n*2^HSIZE bytes.
- Wrap tracking: the wrap tracker is loaded on a NONSEQ and advanced on each accepted SEQ beat. INCR bursts are not sequence-checked.
- States: IDLE, WAIT, ERR1, ERR2.
  - IDLE -> WAIT on an accepted error-free transfer when WAIT_STATES>0.
  - IDLE -> ERR1 on an accepted transfer that fails any check.
  - WAIT: HREADYout=0, HRESP=00. Counts WAIT_STATES cycles, then returns to IDLE and completes with HREADYout=1.
  - ERR1: HREADYout=0, HRESP=01. Always goes to ERR2 next.
  - ERR2: HREADYout=1, HRESP=01. Goes to IDLE. An address phase presented during ERR2 is accepted normally.
- Latency: an OKAY transfer takes WAIT_STATES+1 data-phase cycles. An ERROR takes exactly 2 data-phase cycles.
- Write:
  - Memory is written on the last data-phase cycle (HREADYout=1) using HWDATA.
  - Only lanes [offset, offset+2^HSIZE) are written; other bytes are unchanged. Little-endian.
  - Errored writes never modify memory.
- Read:
  - HRDATA carries the full addressed word, valid when HREADYout=1 in the final data-phase cycle.
  - Unselected lanes carry memory contents.
  - On an ERROR, HRDATA holds its previous value.
- Hazard: a read accepted in the cycle a write data phase completes to the same word returns the merged data. Byte lanes are forwarded from HWDATA.
- HREADYin=0 while no transfer is pending from this block: the registered control signals hold and no new phase is accepted.

Test Plan:
- Reset then idle: HRESET=1 for 2 cycles, HTRANS=00 -> HREADYout=1, HRESP=00, HRDATA=0.
- Word write/read, WAIT_STATES=0: write 0xDEADBEEF @0x8, then read @0x8 back-to-back -> HRDATA=0xDEADBEEF in the first data cycle (forwarding path).
- Byte lane: word @0x4 = 0x11223344; write byte 0xAA @0x6 (HSIZE=0) -> read @0x4 returns 0x11AA3344.
- Errors:
  - Read @0x40 with MEM_DEPTH=16 -> cycle 1 HREADYout=0/HRESP=01, cycle 2 HREADYout=1/HRESP=01, memory unchanged.
  - Halfword @0x1 -> same two-cycle ERROR.
- WRAP4 word burst starting @0x38: beats 0x38, 0x3C, 0x30, 0x34 -> all OKAY. Same burst with a 4th beat @0x40 -> that beat gets ERROR, and that write is dropped.
- WAIT_STATES=3: single write -> HREADYout low for exactly 3 cycles, then high with OKAY. Assert HRESET during the 2nd wait cycle -> next cycle HREADYout=1, HRESP=00, target word unchanged.

Source files
------------

// File: rtl/ahb_sram_subordinate_v2.sv
// ahb_sram_subordinate_v2: AHB-Lite SRAM subordinate with byte-lane writes, wait states and two-cycle ERROR.
module ahb_sram_subordinate_v2 #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 16,
    parameter int WAIT_STATES = 0,
    parameter int SLOT_BITS   = 2
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADYin,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic [1:0]            HRESP,
    output logic                  HREADYout
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int OFFW  = $clog2(LANES);
    localparam int MW    = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
    localparam int IDXW  = ADDR_WIDTH - SLOT_BITS - OFFW;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t                r_state;
    logic                  r_ready, r_err, r_pend, r_write, r_wrap_act;
    logic [MW-1:0]         r_idx;
    logic [OFFW-1:0]       r_off;
    logic [2:0]            r_size;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_wrap_exp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic [IDXW-1:0]       w_idx;
    logic                  w_accept, w_err, w_wr, w_wrap_burst;
    logic [LANES-1:0]      w_wmask;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [ADDR_WIDTH-1:0] w_blk, w_next;

    assign w_idx        = HADDR[ADDR_WIDTH-SLOT_BITS-1:OFFW];
    assign w_accept     = HSEL & HREADYin & HTRANS[1] & r_ready;
    assign w_wrap_burst = ~HBURST[0] & |HBURST[2:1];
    assign w_blk        = ADDR_WIDTH'(1) << (int'(HSIZE) + int'(HBURST[2:1]) + 1);
    // next beat address stays inside the n*2^HSIZE-byte wrap block
    assign w_next       = (HADDR & ~(w_blk - 1'b1)) | ((HADDR + (ADDR_WIDTH'(1) << HSIZE)) & (w_blk - 1'b1));
    assign w_err        = (int'(HSIZE) > OFFW) | (|(HADDR[6:0] & ~(7'h7f << HSIZE))) |
                          (w_idx >= IDXW'(MEM_DEPTH)) | (HTRANS == 2'b11 && r_wrap_act && HADDR != r_wrap_exp);
    assign w_wr         = r_pend & r_write & (r_state == S_IDLE) & ~HRESET;

    always_comb begin
        w_rd_word = r_mem[w_idx[MW-1:0]];
        for (int l = 0; l < LANES; l++) begin
            w_wmask[l] = (l >= int'(r_off)) && (l < int'(r_off) + (1 << r_size));
            if (w_wr && w_wmask[l] && w_idx[MW-1:0] == r_idx) w_rd_word[8*l +: 8] = HWDATA[8*l +: 8];
        end
    end

    always_ff @(posedge HCLK)
        for (int l = 0; l < LANES; l++)
            if (w_wr && w_wmask[l]) r_mem[r_idx][8*l +: 8] <= HWDATA[8*l +: 8];

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b1;
            r_err      <= 1'b0;
            r_pend     <= 1'b0;
            r_cnt      <= '0;
            r_wrap_act <= 1'b0;
            r_wrap_exp <= '0;
            r_rdata    <= '0;
        end else begin
            if (w_accept) begin
                r_write    <= HWRITE;
                r_idx      <= w_idx[MW-1:0];
                r_off      <= HADDR[OFFW-1:0];
                r_size     <= HSIZE;
                r_wrap_exp <= w_next;
                if (HTRANS == 2'b10) r_wrap_act <= w_wrap_burst;
                if (!w_err && !HWRITE) r_rdata <= w_rd_word;
            end
            case (r_state)
                S_WAIT: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'(WAIT_STATES - 1)) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                S_ERR1: begin
                    r_state <= S_ERR2;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_pend  <= w_accept & ~w_err;
                    r_err   <= w_accept & w_err;
                    r_ready <= ~(w_accept & (w_err | (WAIT_STATES > 0)));
                    r_cnt   <= '0;
                    r_state <= !w_accept ? S_IDLE : w_err ? S_ERR1 : (WAIT_STATES > 0) ? S_WAIT : S_IDLE;
                end
            endcase
        end
    end

    assign HRDATA    = r_rdata;
    assign HRESP     = {1'b0, r_err};
    assign HREADYout = r_ready;
endmodule
